// File: rtl/scmi_irq_collector.sv
// scmi_irq_collector
//   Turns the SCMI mailbox's single-cycle doorbell/completion pulses into
//   level, maskable interrupts. Each channel keeps a pending state that is
//   cleared by an explicit ack, plus a saturating event counter. A watchdog
//   flags a doorbell left pending for TIMEOUT_CYCLES cycles.
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   doorbell_pulse_i    1-cycle doorbell event from the mailbox
//   completion_pulse_i  1-cycle completion event from the mailbox
//   db_ack_i, cmp_ack_i clear the doorbell / completion pending state
//   irq_mask_i          [0] doorbell irq enable, [1] completion irq enable
//   cnt_clr_i           synchronous clear of both event counters
//   timeout_clr_i       clears the sticky watchdog flag
//   doorbell_irq_o      level doorbell interrupt
//   completion_irq_o    level completion interrupt
//   db_count_o          saturating doorbell pulse count
//   cmp_count_o         saturating completion pulse count
//   db_timeout_o        sticky watchdog flag
module scmi_irq_collector #(
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 doorbell_pulse_i,
  input  logic                 completion_pulse_i,
  input  logic                 db_ack_i,
  input  logic                 cmp_ack_i,
  input  logic [1:0]           irq_mask_i,
  input  logic                 cnt_clr_i,
  input  logic                 timeout_clr_i,
  output logic                 doorbell_irq_o,
  output logic                 completion_irq_o,
  output logic [CNT_WIDTH-1:0] db_count_o,
  output logic [CNT_WIDTH-1:0] cmp_count_o,
  output logic                 db_timeout_o
);

  localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_WIDTH-1:0] TMR_LAST =
    WDOG_EN ? TMR_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PEND    = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  logic [1:0]           db_state, db_state_nxt;
  logic [1:0]           cmp_state, cmp_state_nxt;
  logic [TMR_WIDTH-1:0] tmr, tmr_nxt;
  logic                 expire;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] db_cnt, cmp_cnt;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 pulse,
    input logic                 clr
  );
    logic [CNT_WIDTH-1:0] base;
    // A clear folds in the same-cycle pulse so nothing is lost.
    base = clr ? '0 : cur;
    if (pulse && (base != '1)) begin
      return base + 1'b1;
    end
    return base;
  endfunction

  // Doorbell channel with watchdog. Pulse beats ack; a pulse+ack while
  // pending re-arms the timer, a lone pulse while pending does not.
  always_comb begin
    db_state_nxt = db_state;
    tmr_nxt      = tmr;
    expire       = 1'b0;
    case (db_state)
      ST_IDLE: begin
        tmr_nxt = '0;
        if (doorbell_pulse_i) begin
          db_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (doorbell_pulse_i && db_ack_i) begin
          tmr_nxt = '0;
        end else if (db_ack_i) begin
          db_state_nxt = ST_IDLE;
          tmr_nxt      = '0;
        end else if (WDOG_EN && (tmr == TMR_LAST)) begin
          db_state_nxt = ST_EXPIRED;
          tmr_nxt      = '0;
          expire       = 1'b1;
        end else if (WDOG_EN) begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      ST_EXPIRED: begin
        tmr_nxt = '0;
        if (doorbell_pulse_i && db_ack_i) begin
          db_state_nxt = ST_PEND;
        end else if (db_ack_i) begin
          db_state_nxt = ST_IDLE;
        end
      end
      default: begin
        db_state_nxt = ST_IDLE;
        tmr_nxt      = '0;
      end
    endcase
  end

  always_comb begin
    cmp_state_nxt = cmp_state;
    case (cmp_state)
      ST_IDLE: begin
        if (completion_pulse_i) begin
          cmp_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (cmp_ack_i && !completion_pulse_i) begin
          cmp_state_nxt = ST_IDLE;
        end
      end
      default: cmp_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_state  <= ST_IDLE;
      cmp_state <= ST_IDLE;
      tmr       <= '0;
      db_cnt    <= '0;
      cmp_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      db_state  <= db_state_nxt;
      cmp_state <= cmp_state_nxt;
      tmr       <= tmr_nxt;
      db_cnt    <= cnt_next(db_cnt, doorbell_pulse_i, cnt_clr_i);
      cmp_cnt   <= cnt_next(cmp_cnt, completion_pulse_i, cnt_clr_i);
      // Set has priority over clear.
      if (expire) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  // Mask gates only the outputs; pending state keeps tracking underneath.
  assign doorbell_irq_o   = (db_state != ST_IDLE) & irq_mask_i[0];
  assign completion_irq_o = (cmp_state != ST_IDLE) & irq_mask_i[1];
  assign db_count_o       = db_cnt;
  assign cmp_count_o      = cmp_cnt;
  assign db_timeout_o     = WDOG_EN ? timeout_q : 1'b0;

endmodule
